// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
// Shared constants for the UART baud timing block.
//   DIV_WIDTH_DEF / FRAC_BITS_DEF : default divisor field widths
//   MIN_DIV                       : smallest usable integer divisor
//   calc_div_fixed / _int / _frac : reset divisor from CLK_HZ and BAUD,
//                                   rounded to the nearest 1/2^FRAC_BITS
//                                   cycle (24 MHz, 19200 baud, x16 gives
//                                   78 + 2/16).
// ---------------------------------------------------------------------------
package baud_pkg;

    localparam int DIV_WIDTH_DEF = 16;
    localparam int FRAC_BITS_DEF = 4;
    localparam int MIN_DIV       = 2;

    // Divisor as an unsigned fixed-point value with frac_bits fraction bits.
    function automatic int unsigned calc_div_fixed(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input int unsigned     oversample,
        input int unsigned     frac_bits
    );
        longint unsigned den;
        longint unsigned num;
        den = baud * 64'(oversample);
        num = (clk_hz << frac_bits) + (den >> 1);
        return 32'(num / den);
    endfunction

    function automatic int unsigned calc_div_int(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input int unsigned     oversample,
        input int unsigned     frac_bits
    );
        return calc_div_fixed(clk_hz, baud, oversample, frac_bits) >> frac_bits;
    endfunction

    function automatic int unsigned calc_div_frac(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input int unsigned     oversample,
        input int unsigned     frac_bits
    );
        int unsigned mask;
        mask = (32'd1 << frac_bits) - 32'd1;
        return calc_div_fixed(clk_hz, baud, oversample, frac_bits) & mask;
    endfunction

endpackage

// File: rtl/frac_tick_divider.sv
// ---------------------------------------------------------------------------
// frac_tick_divider
// Fractional clock divider producing the oversample tick.
// Each period lasts div_int (clamped to MIN_DIV) cycles plus one extra cycle
// whenever the fractional accumulator overflows, so the long-run period is
// div_int + div_frac/2^FRAC_BITS cycles.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   enable        : run when 1; counter and accumulator held cleared when 0
//   restart       : clear counter and accumulator (period restarts)
//   div_int       : active integer divisor
//   div_frac      : active fractional divisor
//   period_done   : combinational, high in the cycle whose closing edge
//                   raises os_tick (lets the parent register coincident ticks)
//   os_tick       : registered one-cycle pulse, last cycle of each period
// ---------------------------------------------------------------------------
module frac_tick_divider
    import baud_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    output logic                 period_done,
    output logic                 os_tick
);

    localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE_C     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH:0]   ONE_P     = (DIV_WIDTH+1)'(1);

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < MIN_DIV_W) ? MIN_DIV_W : d;
    endfunction

    logic [DIV_WIDTH-1:0] cyc_cnt;
    logic [FRAC_BITS-1:0] frac_acc;
    logic [FRAC_BITS:0]   frac_sum;
    logic [DIV_WIDTH-1:0] eff_div;
    logic [DIV_WIDTH:0]   period_len;

    // frac_acc holds the accumulator as it stands at the start of the
    // current period; its carry decides whether this period gets the extra
    // cycle, and it advances when the period closes.
    always_comb begin
        eff_div     = clamp_div(div_int);
        frac_sum    = {1'b0, frac_acc} + {1'b0, div_frac};
        period_len  = {1'b0, eff_div} + {{DIV_WIDTH{1'b0}}, frac_sum[FRAC_BITS]};
        // >= rather than == so a counter can never run past its terminal value
        period_done = enable && !restart && ({1'b0, cyc_cnt} >= (period_len - ONE_P));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt  <= '0;
            frac_acc <= '0;
            os_tick  <= 1'b0;
        end else if (!enable || restart) begin
            cyc_cnt  <= '0;
            frac_acc <= '0;
            os_tick  <= 1'b0;
        end else if (period_done) begin
            cyc_cnt  <= '0;
            frac_acc <= frac_sum[FRAC_BITS-1:0];
            os_tick  <= 1'b1;
        end else begin
            cyc_cnt  <= cyc_cnt + ONE_C;
            os_tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_tick_generator.sv
// ---------------------------------------------------------------------------
// baud_tick_generator
// Programmable baud timing source for the UART TX/RX paths.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   enable     : run when 1; timing cleared (divisors kept) when 0
//   div_int    : new integer divisor, captured on load
//   div_frac   : new fractional divisor, captured on load
//   load       : strobe, capture divisor; applied at the next bit boundary
//                while running, immediately when idle or with resync
//   resync     : strobe, restart bit timing (RX start-bit edge)
//   os_tick    : one pulse per oversample period
//   mid_tick   : pulse at bit centre (os_cnt reaches OVERSAMPLE/2)
//   bit_tick   : pulse at bit end (os_cnt wraps to 0)
//   baud_clk   : square wave toggling on every bit_tick
//   pending    : a loaded divisor is waiting for the next bit boundary
// ---------------------------------------------------------------------------
module baud_tick_generator
    import baud_pkg::*;
#(
    parameter int DIV_WIDTH        = DIV_WIDTH_DEF,
    parameter int FRAC_BITS        = FRAC_BITS_DEF,
    parameter int OVERSAMPLE       = 16,
    parameter int DEFAULT_DIV_INT  = 78,
    parameter int DEFAULT_DIV_FRAC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    input  logic                 load,
    input  logic                 resync,
    output logic                 os_tick,
    output logic                 mid_tick,
    output logic                 bit_tick,
    output logic                 baud_clk,
    output logic                 pending
);

    localparam int              CNT_W     = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] OS_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] OS_MID_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] ONE_OS    = CNT_W'(1);

    logic [DIV_WIDTH-1:0] act_int;
    logic [FRAC_BITS-1:0] act_frac;
    logic [DIV_WIDTH-1:0] pend_int;
    logic [FRAC_BITS-1:0] pend_frac;
    logic [CNT_W-1:0]     os_cnt;
    logic                 period_done;
    logic                 bit_end;
    logic                 apply_now;

    frac_tick_divider #(
        .DIV_WIDTH (DIV_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .restart     (resync),
        .div_int     (act_int),
        .div_frac    (act_frac),
        .period_done (period_done),
        .os_tick     (os_tick)
    );

    // bit_end marks the edge that raises bit_tick: the divisor swap and the
    // baud_clk toggle both happen there.
    assign bit_end   = period_done && (os_cnt == OS_LAST);
    assign apply_now = !enable || resync;

    // Oversample counting, tick decode and baud_clk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            os_cnt   <= '0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            baud_clk <= 1'b0;
        end else if (!enable) begin
            os_cnt   <= '0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            baud_clk <= 1'b0;
        end else if (resync) begin
            // baud_clk keeps its level across a resync
            os_cnt   <= '0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            mid_tick <= period_done && (os_cnt == OS_MID_M1);
            bit_tick <= bit_end;
            if (period_done) begin
                os_cnt <= bit_end ? '0 : (os_cnt + ONE_OS);
            end
            if (bit_end) begin
                baud_clk <= ~baud_clk;
            end
        end
    end

    // Divisor load / apply
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_int   <= DIV_WIDTH'(DEFAULT_DIV_INT);
            act_frac  <= FRAC_BITS'(DEFAULT_DIV_FRAC);
            pend_int  <= DIV_WIDTH'(DEFAULT_DIV_INT);
            pend_frac <= FRAC_BITS'(DEFAULT_DIV_FRAC);
            pending   <= 1'b0;
        end else if (load) begin
            pend_int  <= div_int;
            pend_frac <= div_frac;
            if (apply_now) begin
                // Idle or restarting: nothing mid-bit to protect
                act_int  <= div_int;
                act_frac <= div_frac;
                pending  <= 1'b0;
            end else begin
                pending  <= 1'b1;
            end
        end else if (pending && bit_end) begin
            act_int  <= pend_int;
            act_frac <= pend_frac;
            pending  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_tick_generator.sv
// ---------------------------------------------------------------------------
// tb_baud_tick_generator
// Directed bench for baud_tick_generator. Edge indices are counted from the
// first rising edge after mark(); tick pulses are logged by edge index.
// ---------------------------------------------------------------------------
module tb_baud_tick_generator;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        load;
    logic        resync;
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;
    logic        baud_clk;
    logic        pending;

    int n_chk  = 0;
    int n_pass = 0;
    int ecnt   = 0;
    int os_q[$];
    int mid_q[$];
    int bit_q[$];
    int bc_q[$];
    logic bc_prev = 1'b0;

    baud_tick_generator #(
        .DIV_WIDTH        (16),
        .FRAC_BITS        (4),
        .OVERSAMPLE       (16),
        .DEFAULT_DIV_INT  (78),
        .DEFAULT_DIV_FRAC (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .div_int  (div_int),
        .div_frac (div_frac),
        .load     (load),
        .resync   (resync),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick),
        .baud_clk (baud_clk),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // One rising edge; outputs sampled 1 time unit later, inputs changed there too.
    task automatic step();
        @(posedge clk);
        #1;
        if (os_tick)  os_q.push_back(ecnt);
        if (mid_tick) mid_q.push_back(ecnt);
        if (bit_tick) bit_q.push_back(ecnt);
        if (baud_clk != bc_prev) bc_q.push_back(ecnt);
        bc_prev = baud_clk;
        ecnt++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic mark();
        ecnt = 0;
        os_q.delete();
        mid_q.delete();
        bit_q.delete();
        bc_q.delete();
    endtask

    // Load a divisor while idle (applied immediately), then re-enable.
    task automatic idle_load(input int di, input int df);
        enable   = 1'b0;
        load     = 1'b1;
        div_int  = 16'(di);
        div_frac = 4'(df);
        step();
        load     = 1'b0;
        enable   = 1'b1;
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int in_q(input int q[$], input int e);
        foreach (q[i]) if (q[i] == e) return 1;
        return 0;
    endfunction

    function automatic int first_after(input int q[$], input int e);
        foreach (q[i]) if (q[i] > e) return q[i];
        return -1;
    endfunction

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        resync   = 1'b0;
        div_int  = '0;
        div_frac = '0;
        run(3);
        chk("rst_os", int'(os_tick), 0);
        chk("rst_mid", int'(mid_tick), 0);
        chk("rst_bit", int'(bit_tick), 0);
        chk("rst_baud", int'(baud_clk), 0);
        chk("rst_pend", int'(pending), 0);
        rst_n = 1'b1;

        // Integer divisor 4: os every 4 cycles, mid at 31, bit every 64
        idle_load(4, 0);
        chk("t1_pend_idle", int'(pending), 0);
        mark();
        run(130);
        chk("t1_os0", q_at(os_q, 0), 3);
        chk("t1_os1", q_at(os_q, 1), 7);
        chk("t1_os_cnt", os_q.size(), 32);
        chk("t1_mid0", q_at(mid_q, 0), 31);
        chk("t1_mid1", q_at(mid_q, 1), 95);
        chk("t1_bit0", q_at(bit_q, 0), 63);
        chk("t1_bit1", q_at(bit_q, 1), 127);
        chk("t1_baud_rise", q_at(bc_q, 0), 63);
        chk("t1_baud_fall", q_at(bc_q, 1), 127);

        // 4 + 8/16: periods 4,5,4,5..., 16 ticks in 72 cycles
        idle_load(4, 8);
        mark();
        run(75);
        chk("t2a_os0", q_at(os_q, 0), 3);
        chk("t2a_os1", q_at(os_q, 1), 8);
        chk("t2a_os2", q_at(os_q, 2), 12);
        chk("t2a_os3", q_at(os_q, 3), 17);
        chk("t2a_mid0", q_at(mid_q, 0), 35);
        chk("t2a_bit0", q_at(bit_q, 0), 71);

        // 4 + 2/16: eighth period (and sixteenth) is 5 cycles
        idle_load(4, 2);
        mark();
        run(70);
        chk("t2b_os6", q_at(os_q, 6), 27);
        chk("t2b_os7", q_at(os_q, 7), 32);
        chk("t2b_os8", q_at(os_q, 8), 36);
        chk("t2b_bit0", q_at(bit_q, 0), 65);

        // Mid-bit load of 10: held pending until bit end at 63
        idle_load(4, 0);
        mark();
        run(40);
        load    = 1'b1;
        div_int = 16'd10;
        step();
        load    = 1'b0;
        chk("t3_pend_set", int'(pending), 1);
        run(22);
        chk("t3_pend_hold", int'(pending), 1);
        step();
        chk("t3_bit63", int'(bit_tick), 1);
        chk("t3_pend_clr", int'(pending), 0);
        run(20);
        chk("t3_os59", in_q(os_q, 59), 1);
        chk("t3_no_os67", in_q(os_q, 67), 0);
        chk("t3_os73", in_q(os_q, 73), 1);
        chk("t3_os83", in_q(os_q, 83), 1);

        // Resync in the second bit on an edge where a tick was due (115)
        idle_load(4, 0);
        mark();
        run(115);
        chk("t4_baud_pre", int'(baud_clk), 1);
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("t4_no_tick", int'(os_tick), 0);
        chk("t4_baud_kept", int'(baud_clk), 1);
        run(70);
        chk("t4_next_os", first_after(os_q, 115), 119);
        chk("t4_next_mid", first_after(mid_q, 115), 147);
        chk("t4_next_bit", first_after(bit_q, 115), 179);
        chk("t4_baud_fall", first_after(bc_q, 64), 179);

        // Divisors 0 and 1 clamp to 2
        idle_load(0, 0);
        chk("t5_pend0", int'(pending), 0);
        mark();
        run(8);
        chk("t5_d0_os0", q_at(os_q, 0), 1);
        chk("t5_d0_os1", q_at(os_q, 1), 3);
        idle_load(1, 0);
        mark();
        run(8);
        chk("t5_d1_os0", q_at(os_q, 0), 1);
        chk("t5_d1_os2", q_at(os_q, 2), 5);

        // Load together with resync while running: applied at once
        mark();
        load    = 1'b1;
        resync  = 1'b1;
        div_int = 16'd6;
        step();
        load    = 1'b0;
        resync  = 1'b0;
        chk("t5_lr_pend", int'(pending), 0);
        run(14);
        chk("t5_lr_os0", q_at(os_q, 0), 6);
        chk("t5_lr_os1", q_at(os_q, 1), 12);

        // enable dropped mid-bit with baud_clk high
        idle_load(4, 0);
        mark();
        run(70);
        chk("t6_baud_pre", int'(baud_clk), 1);
        enable = 1'b0;
        step();
        chk("t6_dis_os", int'(os_tick), 0);
        chk("t6_dis_baud", int'(baud_clk), 0);
        mark();
        run(10);
        chk("t6_dis_quiet", os_q.size(), 0);
        enable = 1'b1;
        mark();
        run(70);
        chk("t6_kept_div", q_at(os_q, 0), 3);
        load    = 1'b1;
        div_int = 16'd10;
        step();
        load    = 1'b0;
        chk("t6_pend_set", int'(pending), 1);

        // Reset on edge 71, where an os_tick was due
        rst_n = 1'b0;
        step();
        chk("t6_rst_os", int'(os_tick), 0);
        chk("t6_rst_mid", int'(mid_tick), 0);
        chk("t6_rst_bit", int'(bit_tick), 0);
        chk("t6_rst_baud", int'(baud_clk), 0);
        chk("t6_rst_pend", int'(pending), 0);
        rst_n = 1'b1;
        mark();
        run(160);
        // Default 78 + 2/16: first tick in the 78th cycle, second period also 78
        chk("t6_def_os0", q_at(os_q, 0), 77);
        chk("t6_def_os1", q_at(os_q, 1), 155);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/baud_tick_generator.md
Name: baud_tick_generator

Overview:
Runtime-programmable baud timing source for the UART TX/RX paths. Generates an oversample tick, a mid-bit sample tick and a bit-boundary tick from the system clock. A fractional divider removes baud-rate error at non-integer clock/baud ratios. Supports glitch-free divisor reload and RX start-bit re-synchronisation, and keeps a square-wave baud_clk for legacy consumers.

Parameters:
DIV_WIDTH, 16, width of integer divisor (clk cycles per oversample tick)
FRAC_BITS, 4, width of fractional divisor; fraction = div_frac / 2^FRAC_BITS
OVERSAMPLE, 16, oversample ticks per bit; even, >= 4
DEFAULT_DIV_INT, 78, integer divisor loaded at reset
DEFAULT_DIV_FRAC, 2, fractional divisor loaded at reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active low
enable  input  1  run when 1; when 0, counters are held cleared
div_int  input  DIV_WIDTH  new integer divisor, sampled on load
div_frac  input  FRAC_BITS  new fractional divisor, sampled on load
load  input  1  one-cycle strobe: capture div_int/div_frac into pending registers
resync  input  1  one-cycle strobe: restart bit timing, used on RX start-bit edge
os_tick  output  1  one-cycle pulse per oversample period
mid_tick  output  1  one-cycle pulse at bit centre
bit_tick  output  1  one-cycle pulse at bit end
baud_clk  output  1  toggles on every bit_tick
pending  output  1  1 while a loaded divisor awaits application

Behaviour:
- Reset (rst_n=0 at edge): all counters, frac_acc, and all outputs = 0. Active divisor = DEFAULT_DIV_INT/DEFAULT_DIV_FRAC.
- Effective integer divisor = max(active div_int, 2). Values 0 and 1 are clamped to 2.
- Period start: sum = frac_acc + div_frac (FRAC_BITS+1 bits). frac_acc <= sum[FRAC_BITS-1:0]. Period length P = div_int + sum[FRAC_BITS].
- Average os period = div_int + div_frac/2^FRAC_BITS cycles. frac_acc starts at 0, so the first period has no extra cycle unless div_frac wraps.
- os_tick timing: high for exactly one cycle, in the P-th cycle of each period. Example: div_int=4, frac=0, enable first sampled 1 at edge 0 -> os_tick high after edges 3, 7, 11.
- os_cnt increments per os_tick over the range 0..OVERSAMPLE-1.
- mid_tick: coincides with the os_tick that moves os_cnt to OVERSAMPLE/2.
- bit_tick: coincides with the os_tick that wraps os_cnt to 0, i.e. the OVERSAMPLE-th tick.
- baud_clk: starts at 0 and toggles in the cycle bit_tick is high. Period = 2 bits.
- enable=0: cycle counter, os_cnt, frac_acc, and baud_clk are cleared next edge. No ticks are produced. Active and pending divisors are kept.
- load: pending regs <= inputs and pending <= 1.
  - enable=1: the pending divisor becomes active at the next bit_tick edge, and the following period uses it. pending <= 0 at that edge.
  - enable=0, or simultaneous resync: applied immediately.
  - A second load before application overwrites the pending value.
- resync (enable=1): cycle counter, os_cnt, and frac_acc are cleared at that edge. baud_clk is unchanged. No tick is emitted in that cycle, even if one was due. The next os_tick follows P cycles later, and the next mid_tick follows OVERSAMPLE/2 os_ticks later.
- resync and load in the same cycle: the load is applied first, then timing restarts with the new divisor.
- rst_n has priority over all inputs. Reset asserted mid-bit gives the full reset state, with no partial pulse.

Decomposition:
- Package baud_pkg holds:
  - DIV_WIDTH/FRAC_BITS defaults;
  - the minimum-divisor constant (2);
  - a function for the reset divisor from CLK_HZ/BAUD, for top-level defaults.
- One sub-module: frac_tick_divider (cycle counter + frac accumulator + clamp, outputs os_tick).
- os_cnt, the tick decoding, baud_clk, and load/resync control stay in baud_tick_generator.

Test Plan:
- div_int=4, frac=0, OVERSAMPLE=16, enable held:
  - os_tick every 4 cycles;
  - mid_tick on the 8th os_tick (cycle 31);
  - bit_tick every 64 cycles;
  - baud_clk period 128.
- div_int=4, div_frac=8 (0.5): os periods alternate 4,5,4,5… and 16 os_ticks span exactly 72 cycles. Same check for div_frac=2: extra cycle every 8th period.
- Mid-bit load to div_int=10:
  - pending=1 until the next bit_tick;
  - the old 4-cycle spacing holds up to that bit_tick, then 10-cycle spacing;
  - pending cleared.
- resync asserted on cycle 50 of a bit (div_int=4):
  - no tick on cycle 50;
  - next os_tick at +4;
  - mid_tick at +32;
  - bit_tick at +64;
  - baud_clk level unchanged.
- div_int=0 and div_int=1 loaded with enable=0: immediate application, os_tick every 2 cycles after enable. Simultaneous load+resync also applies immediately.
- enable dropped mid-bit, then rst_n=0 mid-bit: all ticks 0 next cycle and baud_clk=0. After reset release, the default divisor is active (first os_tick at cycle 78).
